alu_pipe: RTL

Parametrised, pipelined successor to the team's N-bit combinational ALU. It selects its operation at run time through an opcode port rather than a build-time parameter, and registers both inputs and results. It also provides carry/overflow/zero flags, optional signed saturation, an internal accumulator and a completed-operation counter. It is the arithmetic block for the datapath exercises and is driven by a valid-qualified operand stream.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_core.sv | 63 ++++++
 rtl/alu_pipe.sv | 92 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encoding for the pipelined ALU and its combinational core.
package alu_pkg;

    localparam int OPC_W = 3;

    localparam logic [OPC_W-1:0] OP_ADD      = 3'b000;
    localparam logic [OPC_W-1:0] OP_OR       = 3'b001;
    localparam logic [OPC_W-1:0] OP_SUB      = 3'b010;
    localparam logic [OPC_W-1:0] OP_XOR      = 3'b011;
    localparam logic [OPC_W-1:0] OP_AND      = 3'b100;
    localparam logic [OPC_W-1:0] OP_ACC_ADD  = 3'b101;
    localparam logic [OPC_W-1:0] OP_ACC_LOAD = 3'b110;
    localparam logic [OPC_W-1:0] OP_RSVD     = 3'b111;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result and carry/overflow/err flags for one opcode,
// with optional signed saturation of the arithmetic ops.
module alu_core
    import alu_pkg::*;
#(
    parameter int N   = 4,
    parameter bit SAT = 1'b0
) (
    input  logic [OPC_W-1:0] opcode,
    input  logic [N-1:0]     in0,
    input  logic [N-1:0]     in1,
    input  logic [N-1:0]     acc,
    output logic [N-1:0]     result,
    output logic             carry,
    output logic             overflow,
    output logic             err
);

    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic [N:0]   sum;
    logic [N:0]   diff;
    logic [N-1:0] sat_val;

    // ACC_ADD reuses the adder with the accumulator as the first operand.
    assign op_a = (opcode == OP_ACC_ADD) ? acc : in0;
    assign op_b = (opcode == OP_ACC_ADD) ? in0 : in1;
    assign sum  = {1'b0, op_a} + {1'b0, op_b};
    assign diff = {1'b0, in0} - {1'b0, in1};

    // Overflow direction follows the sign of the first operand.
    assign sat_val = op_a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        err      = 1'b0;
        unique case (opcode)
            OP_ADD, OP_ACC_ADD: begin
                result   = sum[N-1:0];
                carry    = sum[N];
                overflow = (op_a[N-1] == op_b[N-1]) && (sum[N-1] != op_a[N-1]);
            end
            OP_SUB: begin
                result   = diff[N-1:0];
                carry    = diff[N];
                overflow = (in0[N-1] != in1[N-1]) && (diff[N-1] != in0[N-1]);
            end
            OP_OR:       result = in0 | in1;
            OP_XOR:      result = in0 ^ in1;
            OP_AND:      result = in0 & in1;
            OP_ACC_LOAD: result = in0;
            OP_RSVD:     err    = 1'b1;
            default:     err    = 1'b1;
        endcase
        if (SAT && overflow) begin
            result = sat_val;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: operand register stage, then compute and result
// register stage holding flags, accumulator and completed-op counter.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int N     = 4,
    parameter bit SAT   = 1'b0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [OPC_W-1:0] opcode,
    input  logic [N-1:0]     in0,
    input  logic [N-1:0]     in1,
    output logic             out_valid,
    output logic [N-1:0]     out,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             err,
    output logic [N-1:0]     acc,
    output logic [CNT_W-1:0] op_count
);

    logic             s1_valid;
    logic [OPC_W-1:0] s1_op;
    logic [N-1:0]     s1_in0;
    logic [N-1:0]     s1_in1;

    logic [N-1:0]     core_result;
    logic             core_carry;
    logic             core_overflow;
    logic             core_err;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers update together from pre-edge values.
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_ADD;
            s1_in0   <= '0;
            s1_in1   <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op  <= opcode;
                s1_in0 <= in0;
                s1_in1 <= in1;
            end
        end
    end

    alu_core #(.N(N), .SAT(SAT)) u_core (
        .opcode   (s1_op),
        .in0      (s1_in0),
        .in1      (s1_in1),
        .acc      (acc),
        .result   (core_result),
        .carry    (core_carry),
        .overflow (core_overflow),
        .err      (core_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            err       <= 1'b0;
            acc       <= '0;
            op_count  <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out      <= core_result;
                carry    <= core_carry;
                overflow <= core_overflow;
                zero     <= (core_result == '0);
                err      <= core_err;
                op_count <= op_count + 1'b1;
                // Written on the same edge as out, so a following ACC op sees it.
                if (s1_op == OP_ACC_ADD || s1_op == OP_ACC_LOAD) begin
                    acc <= core_result;
                end
            end
        end
    end

endmodule
